// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states, grant encoding.
package dmem_arb_pkg;

    localparam logic [2:0] SZ_B = 3'b000;
    localparam logic [2:0] SZ_H = 3'b001;
    localparam logic [2:0] SZ_W = 3'b010;

    typedef enum logic {
        ARB,
        DMA_LOCK
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DMA
    } gnt_e;

    // Unsupported encodings report 4 so the range check stays conservative.
    function automatic logic [2:0] size_nbytes(input logic [2:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of one request: supported size and last byte inside memory.
// Zero latency; no flow control.
module dmem_req_check
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic [2:0]  i_size,
    input  logic [31:0] i_addr,
    output logic        o_legal
);

    logic        w_size_ok;
    logic [32:0] w_last_byte;

    assign w_size_ok   = (i_size == SZ_B) || (i_size == SZ_H) || (i_size == SZ_W);
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_last_byte = {1'b0, i_addr} + {30'd0, size_nbytes(i_size)} - 33'd1;
    assign o_legal     = w_size_ok && (w_last_byte < 33'(MEM_BYTES));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between CPU (priority) and DMA (starvation guard, burst lock).
// Grant/ready is combinational; response is registered one cycle after acceptance.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_valid_i,
    output logic        cpu_ready_o,
    input  logic        cpu_wen_i,
    input  logic [2:0]  cpu_size_i,
    input  logic        cpu_signed_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_rsp_valid_o,
    output logic        cpu_rsp_err_o,
    output logic [31:0] cpu_rsp_rdata_o,
    input  logic        dma_valid_i,
    output logic        dma_ready_o,
    input  logic        dma_wen_i,
    input  logic [2:0]  dma_size_i,
    input  logic        dma_signed_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    input  logic        dma_last_i,
    output logic        dma_rsp_valid_o,
    output logic        dma_rsp_err_o,
    output logic [31:0] dma_rsp_rdata_o,
    output logic        mem_wen_o,
    output logic [2:0]  mem_size_o,
    output logic        mem_signed_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_e        r_state, w_state_nxt;
    logic [WW-1:0] r_wait_cnt, w_wait_nxt;
    logic [BW-1:0] r_beat_cnt, w_beat_nxt;
    gnt_e          w_gnt;
    logic          w_cpu_legal, w_dma_legal;

    logic          r_cpu_rsp_vld, r_cpu_rsp_err, r_dma_rsp_vld, r_dma_rsp_err;
    logic [31:0]   r_cpu_rsp_dat, r_dma_rsp_dat;

    dmem_req_check #(.MEM_BYTES(MEM_BYTES)) u_cpu_chk (
        .i_size (cpu_size_i),
        .i_addr (cpu_addr_i),
        .o_legal(w_cpu_legal)
    );

    dmem_req_check #(.MEM_BYTES(MEM_BYTES)) u_dma_chk (
        .i_size (dma_size_i),
        .i_addr (dma_addr_i),
        .o_legal(w_dma_legal)
    );

    always_comb begin
        w_gnt       = GNT_NONE;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_beat_nxt  = r_beat_cnt;
        // Grant is gated by reset so ready and mem_* fall to zero asynchronously.
        if (rst_ni) begin
            if (r_state == DMA_LOCK && dma_valid_i)                  w_gnt = GNT_DMA;
            else if (dma_valid_i && r_wait_cnt >= WW'(MAX_WAIT))     w_gnt = GNT_DMA;
            else if (cpu_valid_i)                                    w_gnt = GNT_CPU;
            else if (dma_valid_i)                                    w_gnt = GNT_DMA;
        end

        if (w_gnt == GNT_DMA) begin
            w_wait_nxt = '0;
            if (r_state == ARB) begin
                if (!dma_last_i && MAX_BURST > 1) begin
                    w_state_nxt = DMA_LOCK;
                    w_beat_nxt  = BW'(1);
                end
            end else begin
                w_beat_nxt = r_beat_cnt + BW'(1);
                if (dma_last_i || w_beat_nxt >= BW'(MAX_BURST)) begin
                    w_state_nxt = ARB;
                    w_beat_nxt  = '0;
                end
            end
        end else begin
            if (!dma_valid_i)                       w_wait_nxt = '0;
            else if (r_wait_cnt < WW'(MAX_WAIT))    w_wait_nxt = r_wait_cnt + WW'(1);
            // Not granting DMA while locked means dma_valid dropped: release the lock.
            if (r_state == DMA_LOCK) begin
                w_state_nxt = ARB;
                w_beat_nxt  = '0;
            end
        end
    end

    always_comb begin
        mem_wen_o    = 1'b0;
        mem_size_o   = '0;
        mem_signed_o = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (w_gnt)
            GNT_CPU: begin
                mem_wen_o    = cpu_wen_i & w_cpu_legal;
                mem_size_o   = cpu_size_i;
                mem_signed_o = cpu_signed_i;
                mem_addr_o   = cpu_addr_i;
                mem_wdata_o  = cpu_wdata_i;
            end
            GNT_DMA: begin
                mem_wen_o    = dma_wen_i & w_dma_legal;
                mem_size_o   = dma_size_i;
                mem_signed_o = dma_signed_i;
                mem_addr_o   = dma_addr_i;
                mem_wdata_o  = dma_wdata_i;
            end
            default: ;
        endcase
    end

    assign cpu_ready_o = (w_gnt == GNT_CPU);
    assign dma_ready_o = (w_gnt == GNT_DMA);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ARB;
            r_wait_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_cpu_rsp_vld <= 1'b0;
            r_cpu_rsp_err <= 1'b0;
            r_cpu_rsp_dat <= '0;
            r_dma_rsp_vld <= 1'b0;
            r_dma_rsp_err <= 1'b0;
            r_dma_rsp_dat <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_beat_cnt    <= w_beat_nxt;
            r_cpu_rsp_vld <= (w_gnt == GNT_CPU);
            r_dma_rsp_vld <= (w_gnt == GNT_DMA);
            if (w_gnt == GNT_CPU) begin
                r_cpu_rsp_err <= ~w_cpu_legal;
                r_cpu_rsp_dat <= (w_cpu_legal && !cpu_wen_i) ? mem_rdata_i : '0;
            end
            if (w_gnt == GNT_DMA) begin
                r_dma_rsp_err <= ~w_dma_legal;
                r_dma_rsp_dat <= (w_dma_legal && !dma_wen_i) ? mem_rdata_i : '0;
            end
        end
    end

    assign cpu_rsp_valid_o = r_cpu_rsp_vld;
    assign cpu_rsp_err_o   = r_cpu_rsp_err;
    assign cpu_rsp_rdata_o = r_cpu_rsp_dat;
    assign dma_rsp_valid_o = r_dma_rsp_vld;
    assign dma_rsp_err_o   = r_dma_rsp_err;
    assign dma_rsp_rdata_o = r_dma_rsp_dat;

endmodule
